rr_arbiter4: RTL

Four-requester round-robin arbiter that shares one downstream write port (a single WIDTH-bit data register or bus) among four sources. It selects one pending requester, captures its data into a registered output stage, and holds it until the downstream consumer accepts it. It drives the 2-bit select that steers the one-hot acknowledge back to the chosen source, as a 1-to-4 demultiplexer does. It sits between the four producers and the shared resource in the CPU/memory-mapped I/O fabric.

---
 rtl/rr_arbiter4_if.sv | 30 +++
 rtl/rr_arbiter4.sv | 98 +++++++++
 2 files changed

// File: rtl/rr_arbiter4_if.sv
// Handshake bundle between four producers, the round-robin arbiter and one consumer.
// Latency: none (wires only); the arbiter defines all timing.
// Backpressure: out_ready from the consumer stalls captures; req_ready acknowledges producers.
// Ports: req_valid/req_data/req_ready (producer side), out_* (consumer side),
//        grant_sel (captured index this cycle), busy (mirror of out_valid).
interface rr_arbiter4_if #(
  parameter int WIDTH = 16
);
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_data;
  logic [3:0]         req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_src;
  logic               out_ready;
  logic [1:0]         grant_sel;
  logic               busy;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, grant_sel, busy
  );

  // Producer/consumer (environment) side.
  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, grant_sel, busy
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter feeding a single registered output word.
// Latency: req_ready is combinational (0 cycles); captured word appears on out_* 1 cycle later.
// Backpressure: while out_valid && !out_ready the word is held and no requester is acknowledged.
// Ports: clk, rst (async active-high); bus (rr_arbiter4_if.master) carries the
//        request, acknowledge, output and status signals.
module rr_arbiter4 #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter4_if.master  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [1:0]         out_src_q, out_src_d;
  logic               out_valid_q, out_valid_d;

  logic               handshake;
  logic               cap;
  logic [1:0]         start;
  logic [1:0]         idx;
  logic [1:0]         win;
  logic [3:0]         req_ready_c;
  logic [1:0]         grant_sel_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    idx         = 2'd0;
    win         = 2'd0;

    handshake = (state_q == SEND) && bus.out_ready;
    // On a handshake the search starts just past the word leaving, so the
    // reload in the same cycle already sees the rotated priority.
    start = handshake ? (out_src_q + 2'd1) : ptr_q;

    // Scan from lowest priority to highest so the last hit is the winner.
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (bus.req_valid[idx]) win = idx;
    end

    // rst gating keeps the acknowledge quiet while the registers are held,
    // so no producer believes a word was taken during reset.
    cap = !rst && (|bus.req_valid) && ((state_q == IDLE) || handshake);

    req_ready_c = cap ? (4'b0001 << win) : 4'b0000;
    grant_sel_c = cap ? win : 2'd0;

    if (handshake) begin
      ptr_d = out_src_q + 2'd1;
    end

    if (cap) begin
      state_d     = SEND;
      out_data_d  = bus.req_data[int'(win)*WIDTH +: WIDTH];
      out_src_d   = win;
      out_valid_d = 1'b1;
    end else if (handshake) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.grant_sel = grant_sel_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = out_valid_q;

endmodule
